// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage-register state and per-stage bundle widths.
package pipe_pkg;

  // The encoding equals the number of held entries.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } ps_state_e;

  // Payload widths of the packed stage bundles (control, PC, operands, register IDs).
  localparam int unsigned IdExeW  = 150;
  localparam int unsigned ExeMemW = 110;
  localparam int unsigned MemWbW  = 72;

  // Number of entries held in a given state.
  function automatic logic [1:0] ps_occupancy(input ps_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    unique case (s)
      PS_EMPTY: occ = 2'd0;
      PS_FULL:  occ = 2'd1;
      PS_SKID:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle of one pipeline stage register.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 150
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  // Environment side: drives upstream data and downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // Stage register side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 150,
  parameter bit          SKID   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_stage_reg_if.slave bus
);

  ps_state_e         r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_skid_q;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_pop;

  assign w_out_valid = (r_state != PS_EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main;
  assign bus.occupancy = ps_occupancy(r_state);

  if (SKID) begin : g_skid
    logic [DATA_W-1:0] r_skid;
    logic              w_skid_push;
    logic              w_skid_pop;

    // Ready comes from state flops only, so no combinational path from out_ready.
    assign w_in_ready  = (r_state != PS_SKID);
    assign w_skid_push = (r_state == PS_FULL) & w_accept & ~w_pop;
    assign w_skid_pop  = (r_state == PS_SKID) & w_pop;
    assign w_skid_q    = r_skid;

    // Skid entry: captures the one in-flight word on a stall, zeroed whenever it empties.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_skid <= '0;
      end else if (flush || w_skid_pop) begin
        r_skid <= '0;
      end else if (w_skid_push) begin
        r_skid <= bus.in_data;
      end
    end
  end else begin : g_no_skid
    // Single entry: accept only when empty or when the head leaves this cycle.
    assign w_in_ready = ~w_out_valid | bus.out_ready;
    assign w_skid_q   = '0;
  end

  // Stage FSM and head entry; main is zeroed on every entry into EMPTY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PS_EMPTY;
      r_main  <= '0;
    end else if (flush) begin
      r_state <= PS_EMPTY;
      r_main  <= '0;
    end else begin
      unique case (r_state)
        PS_EMPTY: begin
          if (w_accept) begin
            r_state <= PS_FULL;
            r_main  <= bus.in_data;
          end
        end
        PS_FULL: begin
          if (w_accept && w_pop) begin
            r_main <= bus.in_data;
          end else if (w_accept) begin
            // Only reachable with a skid entry; without one, accept implies pop.
            if (SKID) begin
              r_state <= PS_SKID;
            end
          end else if (w_pop) begin
            r_state <= PS_EMPTY;
            r_main  <= '0;
          end
        end
        PS_SKID: begin
          if (w_pop) begin
            r_state <= PS_FULL;
            r_main  <= w_skid_q;
          end
        end
        default: begin
          r_state <= PS_EMPTY;
          r_main  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: both SKID variants driven by the same stimulus, each checked
// every cycle against a FIFO model, plus hand-computed literal checks.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg_if #(.DATA_W(DW)) if_s0 ();
  pipe_stage_reg_if #(.DATA_W(DW)) if_s1 ();

  assign if_s0.in_valid  = in_valid;
  assign if_s0.in_data   = in_data;
  assign if_s0.out_ready = out_ready;
  assign if_s1.in_valid  = in_valid;
  assign if_s1.in_data   = in_data;
  assign if_s1.out_ready = out_ready;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0)) u_dut_s0 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (if_s0)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1)) u_dut_s1 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (if_s1)
  );

  always #5 clk = ~clk;

  // Actual outputs, index = SKID value.
  logic          a_valid [2];
  logic          a_ready [2];
  logic [DW-1:0] a_data  [2];
  logic [1:0]    a_occ   [2];

  assign a_valid[0] = if_s0.out_valid;
  assign a_ready[0] = if_s0.in_ready;
  assign a_data[0]  = if_s0.out_data;
  assign a_occ[0]   = if_s0.occupancy;
  assign a_valid[1] = if_s1.out_valid;
  assign a_ready[1] = if_s1.in_ready;
  assign a_data[1]  = if_s1.out_data;
  assign a_occ[1]   = if_s1.occupancy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: count plus up to two entries, head first.
  typedef struct packed {
    int            cnt;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } mstate_t;

  mstate_t m_st [2];

  function automatic logic m_ready(input mstate_t s, input bit skid, input logic ordy);
    return skid ? (s.cnt < 2) : (s.cnt == 0 || ordy);
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input bit skid, input logic fl,
                                         input logic iv, input logic [DW-1:0] id,
                                         input logic ordy);
    mstate_t n;
    logic    acc;
    logic    pop;
    n   = s;
    acc = iv && m_ready(s, skid, ordy);
    pop = (s.cnt > 0) && ordy;
    if (fl) begin
      n.cnt = 0;
    end else begin
      if (pop) begin
        n.e0  = s.e1;
        n.cnt = s.cnt - 1;
      end
      if (acc) begin
        if (n.cnt == 0) n.e0 = id;
        else            n.e1 = id;
        n.cnt = n.cnt + 1;
      end
    end
    return n;
  endfunction

  // Model advances on the same edge as the DUT; reset empties it at once.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st[0] <= '0;
      m_st[1] <= '0;
    end else begin
      m_st[0] <= model_next(m_st[0], 1'b0, flush, in_valid, in_data, out_ready);
      m_st[1] <= model_next(m_st[1], 1'b1, flush, in_valid, in_data, out_ready);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_valid_s%0d", k), 32'(a_valid[k]), 32'(m_st[k].cnt != 0));
      chk($sformatf("model_data_s%0d", k), 32'(a_data[k]),
          (m_st[k].cnt != 0) ? 32'(m_st[k].e0) : 32'd0);
      chk($sformatf("model_occ_s%0d", k), 32'(a_occ[k]), 32'(m_st[k].cnt));
      chk($sformatf("model_ready_s%0d", k), 32'(a_ready[k]),
          32'(m_ready(m_st[k], k == 1, out_ready)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00AB;
    out_ready = 1'b0;
    m_st[0]   = '0;
    m_st[1]   = '0;

    // Reset with a word presented upstream.
    repeat (2) @(posedge clk);
    #1;
    at_neg();
    chk("rst_valid", 32'(if_s1.out_valid), 32'd0);
    chk("rst_data", 32'(if_s1.out_data), 32'd0);
    chk("rst_ready_s1", 32'(if_s1.in_ready), 32'd1);
    chk("rst_ready_s0", 32'(if_s0.in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("first_data", 32'(if_s1.out_data), 32'h00AB);
    chk("first_valid", 32'(if_s1.out_valid), 32'd1);
    chk("first_occ", 32'(if_s1.occupancy), 32'd1);
    chk("s0_ready_low", 32'(if_s0.in_ready), 32'd0);

    // SKID=0: in_ready follows out_ready within the cycle; pop+accept keeps one entry.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    #1;
    chk("s0_ready_follow", 32'(if_s0.in_ready), 32'd1);
    tick();
    at_neg();
    chk("s0_swap_occ", 32'(if_s0.occupancy), 32'd1);
    chk("s0_swap_data", 32'(if_s0.out_data), 32'h0011);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      tick();
      at_neg();
      chk($sformatf("stream_data_%0d", i), 32'(if_s1.out_data), 32'(i));
      chk($sformatf("stream_occ_%0d", i), 32'(if_s1.occupancy), 32'd1);
    end

    // Stall with 5 at the head: 6 goes to skid, 7 waits upstream.
    in_data = 16'd5;
    tick();
    at_neg();
    chk("stall_head5", 32'(if_s1.out_data), 32'd5);
    out_ready = 1'b0;
    in_data   = 16'd6;
    tick();
    at_neg();
    chk("skid_occ", 32'(if_s1.occupancy), 32'd2);
    chk("skid_ready", 32'(if_s1.in_ready), 32'd0);
    chk("skid_head", 32'(if_s1.out_data), 32'd5);
    in_data = 16'd7;
    tick();
    at_neg();
    chk("skid_hold_occ", 32'(if_s1.occupancy), 32'd2);
    out_ready = 1'b1;
    tick();
    at_neg();
    chk("resume_head6", 32'(if_s1.out_data), 32'd6);
    chk("resume_ready", 32'(if_s1.in_ready), 32'd1);
    chk("resume_occ", 32'(if_s1.occupancy), 32'd1);
    tick();
    at_neg();
    chk("resume_head7", 32'(if_s1.out_data), 32'd7);
    in_valid = 1'b0;
    tick();
    at_neg();
    chk("drain_valid", 32'(if_s1.out_valid), 32'd0);
    chk("drain_bubble", 32'(if_s1.out_data), 32'd0);

    // Flush while two entries are held and a new word is offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0021;
    tick();
    in_data = 16'h0022;
    tick();
    at_neg();
    chk("pre_flush_occ", 32'(if_s1.occupancy), 32'd2);
    flush   = 1'b1;
    in_data = 16'h0023;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    at_neg();
    chk("flush_occ", 32'(if_s1.occupancy), 32'd0);
    chk("flush_data", 32'(if_s1.out_data), 32'd0);
    chk("flush_ready", 32'(if_s1.in_ready), 32'd1);
    tick();
    at_neg();
    chk("flush_dropped", 32'(if_s1.out_valid), 32'd0);

    // Reset mid-transfer clears everything without a clock edge.
    tick();
    in_valid = 1'b1;
    in_data  = 16'h0031;
    tick();
    in_data = 16'h0032;
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_occ", 32'(if_s1.occupancy), 32'd0);
    chk("async_rst_valid", 32'(if_s1.out_valid), 32'd0);
    chk("async_rst_data", 32'(if_s1.out_data), 32'd0);
    chk("async_rst_occ_s0", 32'(if_s0.occupancy), 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Random traffic; per-cycle model compare covers order, bound and bubbles.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, flush and optional two-entry skid buffer. It is the successor to the fixed-field stage registers between ID/EXE/MEM/WB. The whole stage bundle is carried as one opaque `DATA_W` payload. Downstream back-pressure stalls the stage without losing data. When `SKID=1`, `in_ready` is driven straight from a flop, which breaks the combinational ready path back through the pipeline.

## Interface
- `DATA_W`, default 150 — payload width in bits; the full stage bundle, including control, PC, operands and register IDs.
- `SKID`, default 1 — 1: two-entry storage, `in_ready` from flop; 0: single entry, `in_ready` combinational.
- `clk  in  1` — single clock; all state changes on the rising edge.
- `rst  in  1` — asynchronous, active-high reset.
- `flush  in  1` — synchronous; discards all held entries and the current input.
- `in_valid  in  1` — upstream presents `in_data`.
- `in_ready  out  1` — stage can accept this cycle.
- `in_data  in  DATA_W` — payload from upstream.
- `out_valid  out  1` — `out_data` holds a valid entry.
- `out_ready  in  1` — downstream consumes this cycle.
- `out_data  out  DATA_W` — head entry.
- `occupancy  out  2` — number of held entries: 0, 1 or 2.

## Operation
- accept = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- Storage: `main_q` always drives `out_data`. `skid_q` exists only when `SKID=1`.
- States: EMPTY (0 entries), FULL (1 entry in main), SKID (2 entries, main + skid; `SKID=1` only).
- EMPTY: accept → FULL, `main_q <= in_data`.
- FULL, accept & pop → FULL, `main_q <= in_data`.
- FULL, accept & !pop → SKID, `skid_q <= in_data` (`SKID=1`).
- FULL, !accept & pop → EMPTY.
- FULL, neither → hold.
- SKID: pop → FULL, `main_q <= skid_q`. No accept is possible in SKID, so no other transition.
- `SKID=1`: `in_ready = (state != SKID)`, decoded from the state flops only, with no path from `out_ready`.
- `SKID=0`: `in_ready = !out_valid | out_ready`. The FULL accept & !pop case cannot occur.
- `out_valid = (state != EMPTY)`.
- `occupancy` = 0 / 1 / 2 for EMPTY / FULL / SKID.
- Bubble rule: `main_q` is zeroed on every entry into EMPTY, so `out_data == 0` whenever `out_valid == 0`. `skid_q` is zeroed whenever it empties.
- Flush: priority over all handshakes. Next state is EMPTY and `main_q`/`skid_q` are zeroed. An `in_data` accepted in the flush cycle is dropped. A pop in the flush cycle still counts as delivered downstream.
- Payload bits are never interpreted; no field-level clearing.

## Timing
- Reset (async assert): state EMPTY, `main_q`/`skid_q` = 0, `out_valid` 0, `out_data` 0, `occupancy` 0, `in_ready` 1.
- Reset release: first accept possible on the first rising edge after deassertion.
- Latency: an entry accepted at edge N appears on `out_data` with `out_valid=1` after edge N.
- Throughput: 1 entry/cycle with `out_ready` held high.
- Stall, `SKID=1`: `out_ready` drop at cycle N → at most one further accept (into skid); `in_ready` low after edge N.
- Resume: `in_ready` high one cycle after the pop from SKID.
- Ordering: strictly FIFO; the skid entry is never output before main.
- Reset mid-transfer: all entries are lost immediately, with no clock required.

## Structure
- Shared `pipe_pkg` holds:
  - the state enum (`PS_EMPTY=2'd0`, `PS_FULL=2'd1`, `PS_SKID=2'd2`);
  - the per-stage bundle width localparams (ID→EXE, EXE→MEM, MEM→WB) used to set `DATA_W` at instantiation.
- No sub-module. The `SKID` variants are a generate branch inside the one module.
- Stage wrappers pack/unpack named fields around this block. Flush is driven by the hazard/branch logic exactly as today.

## Test plan
- Reset with `in_valid=1`, `in_data=0xAB` during reset → `out_valid=0`, `out_data=0`, `in_ready=1`. `0xAB` appears after the first post-release edge.
- Streaming 1,2,3,4 with `out_ready=1` → outputs 1,2,3,4 on consecutive cycles, 1-cycle latency, `occupancy` constant 1.
- `SKID=1`: stream 5,6,7 with `out_ready` dropped while 5 is at the output → 6 lands in skid, `occupancy=2`, `in_ready=0`, 7 held upstream. Raising `out_ready` yields 5,6,7 in order with none lost or duplicated.
- Flush in SKID with `in_valid=1` → next cycle `occupancy=0`, `out_data=0`, `in_ready=1`. The flushed input never appears.
- `SKID=0`, `out_valid=1`, `out_ready=0`, then `out_ready=1` with `in_valid=1` → `in_ready` follows `out_ready` in the same cycle; a simultaneous pop+accept keeps `occupancy=1`.
- Random valid/ready (10k cycles, both `SKID`) against a reference queue → order preserved, no overflow, `out_data==0` whenever `!out_valid`.
